sipo_deser: RTL and testbench
=============================

Name: sipo_deser

Overview:
- Serial-in/parallel-out deserializer; receive-side counterpart of the team's 8-bit PISO transmitter.
- Samples qualified serial bits, aligns frames on a start-of-frame marker, and assembles WIDTH-bit words.
- Presents each word through a one-entry valid/ready output register.
- Flags overrun and framing errors for the downstream consumer.

Parameters:
- WIDTH, 8: bits per word; legal range 2..32.
- LSB_FIRST, 1: 1 = first received bit lands in pdata[0], matching the PISO shift-out order; 0 = first bit lands in pdata[WIDTH-1].

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset; asynchronous assert, active-low (0 = reset).
- sdata  input  1  serial data bit.
- sin_en  input  1  bit qualifier; sdata is sampled only on edges where sin_en=1.
- sof  input  1  start of frame; meaningful only when sin_en=1, and marks that bit as bit 0 of a new word.
- pdata  output  WIDTH  assembled word.
- pdata_valid  output  1  pdata holds an unconsumed word.
- pdata_ready  input  1  consumer accepts pdata on an edge where pdata_valid=1.
- busy  output  1  frame in progress (state SHIFT).
- overrun  output  1  sticky: a completed word was dropped.
- frame_err  output  1  sticky: a partial frame was aborted by a new sof.
- clr_err  input  1  synchronous clear of overrun and frame_err.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE, bit counter=0, shift register=0.
  - pdata=0, pdata_valid=0, busy=0, overrun=0, frame_err=0.
  - Reset mid-frame discards the partial word and any held word.
- State IDLE:
  - sin_en=1 and sof=0: bit ignored.
  - sin_en=1 and sof=1: bit stored as bit 0, counter=1, go to SHIFT.
- State SHIFT:
  - Each sin_en=1 edge stores sdata at index counter and increments the counter.
  - sin_en=0: state, counter and shift register hold; gaps of any length are allowed.
- Bit placement:
  - LSB_FIRST=1: bit k goes to position k.
  - LSB_FIRST=0: bit k goes to position WIDTH-1-k.
- Word completion: the edge sampling bit WIDTH-1 returns to IDLE and offers the word to the output register on that same edge.
  - Latency: pdata_valid is high in the cycle immediately after the last bit is presented.
- sof=1 with sin_en=1 while in SHIFT:
  - Partial word discarded and frame_err set.
  - The bit is taken as bit 0 of a new frame, counter=1, state stays SHIFT.
  - WIDTH=1-style immediate completion is not possible because WIDTH>=2.
- Output register handshake:
  - Accept = pdata_valid & pdata_ready at an edge; pdata_valid then clears unless a new word loads on the same edge.
  - Completed word loads when pdata_valid=0, or when accept occurs on the same edge. pdata_valid is then 1 (back-to-back without a bubble).
  - Completed word while pdata_valid=1 and no accept: new word dropped, pdata unchanged, overrun set.
  - pdata is stable while pdata_valid=1 and not accepted.
- Error flags:
  - overrun and frame_err stay set until clr_err=1 at an edge.
  - Set and clear on the same edge: set wins, flag stays 1.
- Counter width: clog2(WIDTH)+1 bits. The counter never exceeds WIDTH-1 in SHIFT; it wraps to 0 on completion.

Test Plan:
- Reset then single word: WIDTH=8, LSB_FIRST=1, send bits of 0xA5 LSB first with sof on bit 0 and pdata_ready=1 -> pdata=0xA5 and pdata_valid=1 exactly one cycle after the 8th sin_en edge, valid for one cycle, errors 0.
- MSB order and gaps: LSB_FIRST=0, send 0x3C MSB first with random sin_en gaps of 0-5 cycles -> pdata=0x3C; busy high from the first bit through the 8th sampled bit.
- Backpressure and overrun: pdata_ready=0, send 0x11 then 0x22 -> pdata stays 0x11, pdata_valid=1, overrun=1. Assert clr_err -> overrun=0 and pdata still 0x11.
- Accept on completion edge: hold 0x11 and raise pdata_ready on the edge that completes 0x22 -> pdata=0x22, pdata_valid stays 1, overrun=0.
- Frame abort: send 3 bits, then sof with bits of 0x5A -> frame_err=1 and pdata=0x5A. Bits without sof while in IDLE produce no word.
- Async reset mid-frame: drop rst after 4 bits with a word held -> all outputs 0 immediately without a clock edge. After release, a new frame of 0xFF yields pdata=0xFF.

Source files
------------

// File: rtl/sipo_deser.sv
// sipo_deser: serial-in/parallel-out deserializer with sof framing and a valid/ready output register
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous reset, active-low
//   sdata        serial data bit, sampled when sin_en=1
//   sin_en       bit qualifier
//   sof          start of frame, marks the qualified bit as bit 0 of a new word
//   pdata        assembled word
//   pdata_valid  pdata holds an unconsumed word
//   pdata_ready  consumer accepts pdata when pdata_valid=1
//   busy         frame in progress
//   overrun      sticky: a completed word was dropped
//   frame_err    sticky: a partial frame was aborted by a new sof
//   clr_err      synchronous clear of overrun and frame_err
module sipo_deser #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sdata,
    input  logic             sin_en,
    input  logic             sof,
    output logic [WIDTH-1:0] pdata,
    output logic             pdata_valid,
    input  logic             pdata_ready,
    output logic             busy,
    output logic             overrun,
    output logic             frame_err,
    input  logic             clr_err
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n, idx, pos;
    logic [WIDTH-1:0] sreg, sreg_n, word, pdata_n;
    logic             valid_n, ovr_n, fe_n, take, done, accept;

    assign busy = (state == SHIFT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            cnt         <= '0;
            sreg        <= '0;
            pdata       <= '0;
            pdata_valid <= 1'b0;
            overrun     <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sreg        <= sreg_n;
            pdata       <= pdata_n;
            pdata_valid <= valid_n;
            overrun     <= ovr_n;
            frame_err   <= fe_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        sreg_n  = sreg;
        pdata_n = pdata;
        valid_n = pdata_valid;
        ovr_n   = overrun & ~clr_err;
        fe_n    = frame_err & ~clr_err;
        // a sof bit always restarts at index 0, discarding any partial word
        idx     = sof ? '0 : cnt;
        pos     = LSB_FIRST ? idx : LAST - idx;
        take    = sin_en & (sof | (state == SHIFT));
        done    = take & (idx == LAST);
        accept  = pdata_valid & pdata_ready;
        word    = sof ? '0 : sreg;
        for (int i = 0; i < WIDTH; i++)
            if (pos == CW'(i)) word[i] = sdata;
        if (take) begin
            sreg_n  = done ? '0 : word;
            cnt_n   = done ? '0 : idx + 1'b1;
            state_n = done ? IDLE : SHIFT;
            if (sof && state == SHIFT) fe_n = 1'b1;
        end
        if (accept) valid_n = 1'b0;
        // the held word wins over a new one unless it is consumed on this same edge
        if (done) begin
            if (!pdata_valid || accept) begin
                pdata_n = word;
                valid_n = 1'b1;
            end else begin
                ovr_n = 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sipo_deser.sv
// tb_sipo_deser: directed self-checking bench for sipo_deser in both bit orders
module tb_sipo_deser;
    logic       clk, rst, sdata, sin_en, sof, pdata_ready, clr_err;
    logic [7:0] pd_l, pd_m;
    logic       v_l, v_m, b_l, b_m, o_l, o_m, f_l, f_m;
    int         n_cmp = 0;
    int         n_err = 0;

    sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
        .clk(clk), .rst(rst), .sdata(sdata), .sin_en(sin_en), .sof(sof),
        .pdata(pd_l), .pdata_valid(v_l), .pdata_ready(pdata_ready),
        .busy(b_l), .overrun(o_l), .frame_err(f_l), .clr_err(clr_err)
    );

    sipo_deser #(.WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
        .clk(clk), .rst(rst), .sdata(sdata), .sin_en(sin_en), .sof(sof),
        .pdata(pd_m), .pdata_valid(v_m), .pdata_ready(pdata_ready),
        .busy(b_m), .overrun(o_m), .frame_err(f_m), .clr_err(clr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic s);
        sdata  = b;
        sof    = s;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
        sof    = 1'b0;
    endtask

    // msb=1 sends w[7] first; gap = max idle cycles between bits; rl raises ready for the last bit
    task automatic send_word(input logic [7:0] w, input bit msb, input int gap, input bit rl);
        for (int i = 0; i < 8; i++) begin
            if (rl && i == 7) pdata_ready = 1'b1;
            send_bit(msb ? w[7-i] : w[i], i == 0);
            if (i < 7) begin
                chk("busy_mid", {31'b0, b_l}, 32'd1);
                for (int g = $urandom_range(gap, 0); g > 0; g--) tick();
            end
        end
    endtask

    initial begin
        rst = 1'b0; sdata = 1'b0; sin_en = 1'b0; sof = 1'b0;
        pdata_ready = 1'b0; clr_err = 1'b0;
        tick();
        chk("rst_pdata", {24'b0, pd_l}, 32'h0);
        chk("rst_valid", {31'b0, v_l}, 32'd0);
        chk("rst_busy", {31'b0, b_l}, 32'd0);
        chk("rst_errs", {30'b0, o_l, f_l}, 32'd0);
        rst = 1'b1;
        tick();

        pdata_ready = 1'b1;
        send_word(8'hA5, 1'b0, 0, 1'b0);
        chk("a5_pdata", {24'b0, pd_l}, 32'hA5);
        chk("a5_valid", {31'b0, v_l}, 32'd1);
        chk("a5_busy", {31'b0, b_l}, 32'd0);
        chk("a5_errs", {30'b0, o_l, f_l}, 32'd0);
        chk("a5_msb_pdata", {24'b0, pd_m}, 32'hA5);
        tick();
        chk("a5_valid_one", {31'b0, v_l}, 32'd0);

        send_word(8'h3C, 1'b1, 5, 1'b0);
        chk("3c_pdata", {24'b0, pd_m}, 32'h3C);
        chk("3c_valid", {31'b0, v_m}, 32'd1);
        chk("3c_busy", {31'b0, b_m}, 32'd0);
        tick();

        pdata_ready = 1'b0;
        send_word(8'h11, 1'b0, 0, 1'b0);
        chk("11_pdata", {24'b0, pd_l}, 32'h11);
        chk("11_msb_pdata", {24'b0, pd_m}, 32'h88);
        send_word(8'h22, 1'b0, 0, 1'b0);
        chk("ovr_pdata", {24'b0, pd_l}, 32'h11);
        chk("ovr_valid", {31'b0, v_l}, 32'd1);
        chk("ovr_flag", {31'b0, o_l}, 32'd1);
        chk("ovr_msb_flag", {31'b0, o_m}, 32'd1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_ovr", {31'b0, o_l}, 32'd0);
        chk("clr_pdata", {24'b0, pd_l}, 32'h11);

        send_word(8'h22, 1'b0, 0, 1'b1);
        chk("acc_pdata", {24'b0, pd_l}, 32'h22);
        chk("acc_valid", {31'b0, v_l}, 32'd1);
        chk("acc_ovr", {31'b0, o_l}, 32'd0);
        tick();
        chk("acc_drain", {31'b0, v_l}, 32'd0);

        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        chk("abort_fe0", {31'b0, f_l}, 32'd0);
        send_word(8'h5A, 1'b0, 0, 1'b0);
        chk("abort_fe", {31'b0, f_l}, 32'd1);
        chk("abort_pdata", {24'b0, pd_l}, 32'h5A);
        chk("abort_valid", {31'b0, v_l}, 32'd1);
        tick();
        for (int i = 0; i < 8; i++) send_bit(1'b1, 1'b0);
        chk("idle_valid", {31'b0, v_l}, 32'd0);
        chk("idle_busy", {31'b0, b_l}, 32'd0);
        chk("idle_pdata", {24'b0, pd_l}, 32'h5A);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        chk("clr_fe", {31'b0, f_l}, 32'd0);

        pdata_ready = 1'b0;
        send_word(8'h77, 1'b0, 0, 1'b0);
        send_bit(1'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b1);
        chk("pre_rst_state", {28'b0, v_l, b_l, f_l, o_l}, 32'hE);
        chk("pre_rst_pdata", {24'b0, pd_l}, 32'h77);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_pdata", {16'b0, pd_l, pd_m}, 32'h0);
        chk("arst_flags", {24'b0, v_l, b_l, f_l, o_l, v_m, b_m, f_m, o_m}, 32'h0);
        tick();
        rst = 1'b1;
        pdata_ready = 1'b1;
        send_word(8'hFF, 1'b0, 2, 1'b0);
        chk("ff_pdata", {24'b0, pd_l}, 32'hFF);
        chk("ff_valid", {31'b0, v_l}, 32'd1);
        chk("ff_errs", {30'b0, o_l, f_l}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
